rom_writer: RTL and testbench
=============================

// Module: rom_writer
// PURPOSE
//  Programmer counterpart of rom_reader: drives a PROM (default 3601/556PT4, 256x4) through timed program cycles.
//  Each cycle is setup -> program pulse -> recovery -> read-back verify, with bounded retries.
//  Sits between the operator/host controls and the chip socket pins, alongside rom_reader.
// PARAMETERS
//  DATA_WIDTH      4   chip data bus width
//  ADDRESS_WIDTH   8   chip address bus width
//  SETUP_CYCLES    2   address/data stable before pulse (>=1)
//  PULSE_CYCLES    10  program_pulse high time (>=1)
//  RECOVER_CYCLES  2   data held after pulse falls (>=1)
//  MAX_ATTEMPTS    4   pulse attempts per word before FAIL (>=1)
// PORTS
//  clk                clk   in   1    system clock, all logic on rising edge
//  reset_n            in   1    asynchronous, active-low reset
//  start              in   1    program write_data at current address (sampled in IDLE only)
//  write_data         in   DW   target word
//  increment_address  in   1    address +1 (IDLE only)
//  decrement_address  in   1    address -1 (IDLE only)
//  data_line_in       in   DW   chip data pins, read-back
//  address_line       out  AW   chip address pins
//  data_line          out  DW   data driven to chip while programming
//  data_oe            out  1    1 = data_line drives chip pins
//  program_pulse      out  1    programming voltage enable
//  chip_select_n      out  1    chip read enable, active-low
//  busy               out  1    FSM not in IDLE
//  done               out  1    one-cycle pulse, word verified
//  error              out  1    sticky failure flag
//  operation          out  4    current state code
// BEHAVIOUR
//  Reset: all outputs 0 except chip_select_n=1; FSM IDLE; attempt count 0.
//  Reset mid-operation: program_pulse drops asynchronously; no partial state survives.
//  Operation codes: IDLE=0 SETUP=1 PULSE=2 RECOVER=3 VERIFY=4 DONE=5 FAIL=6.
//  IDLE:
//   - inc alone: address+1; dec alone: address-1; both or neither: hold.
//   - Address wraps modulo 2^AW: 0xFF+1=0x00, 0x00-1=0xFF.
//   - start: latch write_data, clear error and attempt count, go to SETUP.
//     start wins over inc/dec in the same cycle; address is unchanged.
//  SETUP:   data_oe=1, data_line=latched word, chip_select_n=1; lasts SETUP_CYCLES, then PULSE.
//  PULSE:   program_pulse=1 for PULSE_CYCLES; attempt count +1 on entry; then RECOVER.
//  RECOVER: program_pulse=0, data still driven; lasts RECOVER_CYCLES, then VERIFY.
//  VERIFY:  data_oe=0, chip_select_n=0 for 2 cycles; data_line_in sampled on the 2nd cycle.
//   - read == target: go to DONE.
//   - Bit set in read but clear in target (irreversible fuse): go to FAIL, no retry.
//   - Other mismatch: retry via SETUP if attempts < MAX_ATTEMPTS, else FAIL.
//  DONE: done=1 for one cycle; address auto-increments (with wrap); then IDLE.
//  FAIL: error=1 for one cycle in FAIL, then IDLE; error stays 1 until next start or reset.
//  Inputs other than reset_n are ignored while busy.
//  Latency at defaults, first-try success: done rises 16 edges after the edge that samples start.
//  Each retry adds SETUP+PULSE+RECOVER+2 = 16 cycles.
// CONFIGURATION
//  ROM_WRITER_BLANK_CHECK_EN defined:
//   - start enters VERIFY first (pre-read), attempt count 0.
//   - Pre-read == target: DONE with zero pulses.
//   - Irreversible mismatch: FAIL.
//   - Otherwise: SETUP as normal.
//  Not defined: start always goes straight to SETUP.
// STRUCTURE
//  rom_chip_defs.vh (shared with rom_reader): operation/state codes, default widths for 3601.
//  Sub-module rom_writer_timer: loadable down-counter.
//   - Loaded with phase length on state entry; asserts expired when it reaches 1.
//   - Used by SETUP, PULSE, RECOVER and VERIFY.
// TESTING
//  T1 start, write_data=4'h5, chip model returns 5 after 1st pulse
//     -> 1 pulse of 10 cycles; done at edge 16; address 0->1; error=0.
//  T2 model needs 3 pulses to read 4'hA -> 3 program_pulse bursts; done; attempt count 3.
//  T3 model never programs (reads 0), target 4'h3 -> 4 pulses; FAIL (op=6); error stays 1 until next start.
//  T4 model reads 4'h8, target 4'h1 -> FAIL after 1st verify; no 2nd pulse.
//  T5 address=0xFF, success -> address 0x00; then inc+dec in same cycle -> address held.
//  T6 reset_n low mid-PULSE -> program_pulse=0 immediately; all outputs at reset values.
//     With BLANK_CHECK_EN: model reads target already -> done with zero pulses.

Source files
------------

// File: rtl/rom_writer_pkg.sv
// rtl/rom_writer_pkg.sv - state codes, 3601 default widths and phase lengths for rom_writer
package rom_writer_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 4;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int TIMER_WIDTH           = 16;
  localparam int VERIFY_CYCLES         = 2;

  typedef enum logic [3:0] {
    OP_IDLE    = 4'd0,
    OP_SETUP   = 4'd1,
    OP_PULSE   = 4'd2,
    OP_RECOVER = 4'd3,
    OP_VERIFY  = 4'd4,
    OP_DONE    = 4'd5,
    OP_FAIL    = 4'd6
  } op_e;

  // Timed phases only; DONE/FAIL/IDLE never consult the timer.
  function automatic int phase_len(op_e s, int setup, int pulse, int recover);
    case (s)
      OP_SETUP:   return setup;
      OP_PULSE:   return pulse;
      OP_RECOVER: return recover;
      OP_VERIFY:  return VERIFY_CYCLES;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/rom_writer_timer.sv
// rtl/rom_writer_timer.sv - loadable phase down-counter; expired while the count sits at 1
module rom_writer_timer
  import rom_writer_pkg::*;
#(
  parameter int W = TIMER_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/rom_writer.sv
// rtl/rom_writer.sv - PROM programmer: setup/pulse/recover/verify cycles with bounded retries
// Optional pre-read blank check enabled by defining ROM_WRITER_BLANK_CHECK_EN.
module rom_writer
  import rom_writer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 10,
  parameter int RECOVER_CYCLES = 2,
  parameter int MAX_ATTEMPTS   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     increment_address,
  input  logic                     decrement_address,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    data_line,
  output logic                     data_oe,
  output logic                     program_pulse,
  output logic                     chip_select_n,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [3:0]               operation
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
`ifdef ROM_WRITER_BLANK_CHECK_EN
  localparam op_e START_STATE = OP_VERIFY;
`else
  localparam op_e START_STATE = OP_SETUP;
`endif

  op_e                   state, next_state;
  logic [DATA_WIDTH-1:0] target;
  logic [ATT_W-1:0]      attempts;
  logic                  expired, load;
  logic [TIMER_WIDTH-1:0] load_value;
  logic                  verify_pass, verify_fuse, drive_data;

  assign verify_pass = (data_line_in == target);
  // A bit already blown where the target wants it clear can never be undone.
  assign verify_fuse = |(data_line_in & ~target);

  always_comb begin
    next_state = state;
    case (state)
      OP_IDLE:    if (start) next_state = START_STATE;
      OP_SETUP:   if (expired) next_state = OP_PULSE;
      OP_PULSE:   if (expired) next_state = OP_RECOVER;
      OP_RECOVER: if (expired) next_state = OP_VERIFY;
      OP_VERIFY: begin
        if (expired) begin
          if (verify_pass)                        next_state = OP_DONE;
          else if (verify_fuse)                   next_state = OP_FAIL;
          else if (attempts < ATT_W'(MAX_ATTEMPTS)) next_state = OP_SETUP;
          else                                    next_state = OP_FAIL;
        end
      end
      default:    next_state = OP_IDLE;
    endcase
  end

  assign load       = (next_state != state);
  assign load_value = TIMER_WIDTH'(phase_len(next_state, SETUP_CYCLES, PULSE_CYCLES, RECOVER_CYCLES));
  assign drive_data = (next_state == OP_SETUP) || (next_state == OP_PULSE) || (next_state == OP_RECOVER);

  rom_writer_timer #(.W(TIMER_WIDTH)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .value   (load_value),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= OP_IDLE;
      address_line  <= '0;
      target        <= '0;
      attempts      <= '0;
      data_line     <= '0;
      data_oe       <= 1'b0;
      program_pulse <= 1'b0;
      chip_select_n <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      operation     <= 4'd0;
    end else begin
      state         <= next_state;
      operation     <= next_state;
      busy          <= (next_state != OP_IDLE);
      data_oe       <= drive_data;
      // On the start edge the word is not latched yet, so drive it straight from the input.
      data_line     <= drive_data ? ((state == OP_IDLE) ? write_data : target) : '0;
      program_pulse <= (next_state == OP_PULSE);
      chip_select_n <= (next_state != OP_VERIFY);
      done          <= (next_state == OP_DONE);

      if (state == OP_IDLE) begin
        if (start) begin
          target   <= write_data;
          attempts <= '0;
          error    <= 1'b0;
        end else if (increment_address && !decrement_address) begin
          address_line <= address_line + 1'b1;
        end else if (decrement_address && !increment_address) begin
          address_line <= address_line - 1'b1;
        end
      end

      if (next_state == OP_PULSE && state != OP_PULSE) attempts <= attempts + 1'b1;
      if (next_state == OP_DONE) address_line <= address_line + 1'b1;
      if (next_state == OP_FAIL) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_writer.sv
// tb/tb_rom_writer.sv - scoreboard bench for rom_writer with a fuse-level PROM model
module tb_rom_writer;

  localparam int DW   = 4;
  localparam int AW   = 8;
  localparam int MAXA = 4;
`ifdef ROM_WRITER_BLANK_CHECK_EN
  localparam int PRE    = 2;
  localparam int KSTART = 0;
`else
  localparam int PRE    = 0;
  localparam int KSTART = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          inc = 1'b0;
  logic          dec = 1'b0;
  logic [DW-1:0] data_line_in;
  logic [AW-1:0] address_line;
  logic [DW-1:0] data_line;
  logic          data_oe, program_pulse, chip_select_n, busy, done, error;
  logic [3:0]    operation;

  rom_writer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .write_data        (write_data),
    .increment_address (inc),
    .decrement_address (dec),
    .data_line_in      (data_line_in),
    .address_line      (address_line),
    .data_line         (data_line),
    .data_oe           (data_oe),
    .program_pulse     (program_pulse),
    .chip_select_n     (chip_select_n),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .operation         (operation)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ok;
    int          pulses;
    int          latency;
    logic [7:0]  addr;
  } txn_t;

  typedef struct {
    bit          timeout;
    logic [7:0]  addr;
    bit          error, busy, done, pp, oe, cs_n;
    int          op;
    logic [3:0]  dl;
  } snap_t;

  txn_t  txn_q[$];
  snap_t snap_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    chip_pulses = 0;
  int    pulse_base = 0;
  int    cur_need = 0;
  logic [DW-1:0] cur_target = '0;
  logic [DW-1:0] cur_blank = '0;
  logic [7:0]    addr_model = '0;
  bit            err_model = 1'b0;

  // Chip: fuses read as blank until enough pulses land, then target bits are blown in.
  assign data_line_in = (cur_need != 0 && (chip_pulses - pulse_base) >= cur_need) ?
                        (cur_blank | cur_target) : cur_blank;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge program_pulse) chip_pulses <= chip_pulses + 1;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares snapshots and completed transactions against the queues.
  initial begin
    bit    in_txn;
    int    t0, p0;
    snap_t s;
    txn_t  e;
    in_txn = 0; t0 = 0; p0 = 0;
    forever begin
      @(negedge clk);
      if (snap_q.size() != 0) begin
        s = snap_q.pop_front();
        if (s.timeout) chk("wait_bound", 1, 0);
        else begin
          chk("address", int'(address_line), int'(s.addr));
          chk("error", int'(error), int'(s.error));
          chk("busy", int'(busy), int'(s.busy));
          chk("done", int'(done), int'(s.done));
          chk("program_pulse", int'(program_pulse), int'(s.pp));
          chk("data_oe", int'(data_oe), int'(s.oe));
          chk("chip_select_n", int'(chip_select_n), int'(s.cs_n));
          chk("operation", int'(operation), s.op);
          if (s.oe) chk("data_line", int'(data_line), int'(s.dl));
        end
      end
      if (!reset_n) in_txn = 0;
      else if (!in_txn && busy) begin
        in_txn = 1; t0 = cyc; p0 = chip_pulses;
      end else if (in_txn && (done || operation == 4'd6)) begin
        in_txn = 0;
        if (txn_q.size() == 0) chk("txn_queue_empty", 0, 1);
        else begin
          e = txn_q.pop_front();
          chk("outcome_done", int'(done), int'(e.ok));
          chk("pulse_count", chip_pulses - p0, e.pulses);
          chk("latency", cyc - t0, e.latency);
          chk("end_address", int'(address_line), int'(e.addr));
        end
      end
    end
  end

  task automatic push_idle();
    snap_t s;
    s.timeout = 0; s.addr = addr_model; s.error = err_model; s.busy = 0; s.done = 0;
    s.pp = 0; s.oe = 0; s.cs_n = 1; s.op = 0; s.dl = '0;
    snap_q.push_back(s);
  endtask

  task automatic push_reset();
    snap_t s;
    s.timeout = 0; s.addr = '0; s.error = 0; s.busy = 0; s.done = 0;
    s.pp = 0; s.oe = 0; s.cs_n = 1; s.op = 0; s.dl = '0;
    snap_q.push_back(s);
  endtask

  task automatic push_timeout();
    snap_t s;
    s.timeout = 1; s.addr = '0; s.error = 0; s.busy = 0; s.done = 0;
    s.pp = 0; s.oe = 0; s.cs_n = 0; s.op = 0; s.dl = '0;
    snap_q.push_back(s);
  endtask

  task automatic step(bit i, bit d);
    inc = i; dec = d;
    @(posedge clk); #1;
    inc = 0; dec = 0;
    if (i && !d) addr_model = addr_model + 8'd1;
    else if (d && !i) addr_model = addr_model - 8'd1;
    push_idle();
  endtask

  task automatic run_txn(logic [DW-1:0] tgt, logic [DW-1:0] blank, int need);
    bit         ok, decided, idle_seen;
    int         k;
    logic [3:0] rd;
    txn_t       e;
    snap_t      s;
    ok = 0; decided = 0; k = MAXA; idle_seen = 0;
    for (int a = KSTART; a <= MAXA && !decided; a++) begin
      rd = (need != 0 && a >= need) ? (blank | tgt) : blank;
      if (rd == tgt) begin ok = 1; decided = 1; k = a; end
      else if ((rd & ~tgt) != 0) begin decided = 1; k = a; end
    end
    e.ok = ok; e.pulses = k; e.latency = PRE + 16 * k;
    e.addr = ok ? addr_model + 8'd1 : addr_model;
    txn_q.push_back(e);

    cur_target = tgt; cur_blank = blank; cur_need = need; pulse_base = chip_pulses;
    write_data = tgt; start = 1;
    inc = 1'($urandom_range(0, 1)); dec = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 0; inc = 0; dec = 0; write_data = 4'($urandom);
    s.timeout = 0; s.addr = addr_model; s.error = 0; s.busy = 1; s.done = 0; s.pp = 0; s.dl = tgt;
`ifdef ROM_WRITER_BLANK_CHECK_EN
    s.op = 4; s.oe = 0; s.cs_n = 0;
`else
    s.op = 1; s.oe = 1; s.cs_n = 1;
`endif
    snap_q.push_back(s);

    for (int c = 0; c < 2000 && !idle_seen; c++) begin
      @(posedge clk); #1;
      if (!busy) idle_seen = 1;
      else if (operation >= 4'd1 && operation <= 4'd4) begin
        start = 1'($urandom_range(0, 1)); inc = 1'($urandom_range(0, 1));
        dec = 1'($urandom_range(0, 1)); write_data = 4'($urandom);
      end else begin
        start = 0; inc = 0; dec = 0;
      end
    end
    start = 0; inc = 0; dec = 0;
    addr_model = e.addr; err_model = !ok;
    if (idle_seen) push_idle();
    else push_timeout();
  endtask

  initial begin
    bit found;
    logic [DW-1:0] t, b;
    repeat (2) @(posedge clk); #1;
    push_reset();
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;

    run_txn(4'h5, 4'h0, 1);
    run_txn(4'hA, 4'h0, 3);
    run_txn(4'h3, 4'h0, 0);
    step(1, 0);
    run_txn(4'h1, 4'h8, 1);

    for (int n = 0; n < 300 && addr_model != 8'hFF; n++) step(0, 1);
    run_txn(4'h6, 4'h0, 1);
    step(1, 1);
    step(0, 1);
    step(1, 0);
    run_txn(4'h7, 4'h7, 2);

    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 3) == 0) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else begin
        t = 4'($urandom);
        b = ($urandom_range(0, 9) < 7) ? (t & 4'($urandom)) : 4'($urandom);
        run_txn(t, b, int'($urandom_range(0, 5)));
      end
    end

    // Reset in the middle of a program pulse.
    cur_target = 4'h5; cur_blank = 4'h0; cur_need = 0; pulse_base = chip_pulses;
    write_data = 4'h5; start = 1;
    @(posedge clk); #1;
    start = 0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (program_pulse) found = 1;
    end
    if (!found) push_timeout();
    #1;
    reset_n = 0;
    push_reset();
    @(posedge clk); #1;
    reset_n = 1;
    addr_model = '0; err_model = 0;
    push_idle();
    @(posedge clk); #1;
    run_txn(4'h9, 4'h1, 2);

    repeat (3) @(posedge clk);
    if (txn_q.size() != 0) begin
      push_timeout();
      repeat (2) @(posedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
